// File: rtl/gc_controller_poller_if.sv
// gc_controller_poller_if: open-drain controller line plus decoded controller status bus
// data_in  raw line level seen at the pad (driven by the pad side)
// data_oe  1 = pull the line low, 0 = release to the pull-up
// A..D_LEFT digital buttons, JOY/C_STICK/TRIGGER analog bytes, update pulse, connected flag
interface gc_controller_poller_if;
  logic data_in, data_oe;
  logic A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT;
  logic [7:0] JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, L_TRIGGER, R_TRIGGER;
  logic update, connected;
  modport master (
    input data_in,
    output data_oe, A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT,
    output JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, L_TRIGGER, R_TRIGGER, update, connected
  );
  modport slave (
    output data_in,
    input data_oe, A, B, X, Y, start_pause, L, R, Z, D_UP, D_DOWN, D_RIGHT, D_LEFT,
    input JOY_X, JOY_Y, C_STICK_X, C_STICK_Y, L_TRIGGER, R_TRIGGER, update, connected
  );
endinterface

// File: rtl/gc_controller_poller.sv
// gc_controller_poller: GameCube controller link master, polls 0x400300 and decodes the 64-bit reply
// clk    system clock
// reset  asynchronous, active-high
// bus    gc_controller_poller_if.master: line (data_in/data_oe) and registered decoded outputs
module gc_controller_poller #(
  parameter int US_CYCLES      = 100,
  parameter int POLL_PERIOD_US = 1000,
  parameter int FIRST_TO_US    = 100,
  parameter int BIT_TO_US      = 8
) (
  input logic clk,
  input logic reset,
  gc_controller_poller_if.master bus
);
  localparam int POLL = POLL_PERIOD_US * US_CYCLES;
  localparam int PW = $clog2(POLL);
  localparam int CW = $clog2((FIRST_TO_US + BIT_TO_US + 4) * US_CYCLES);
  localparam logic [24:0] TX_WORD = {24'h400300, 1'b1};
  localparam logic [CW-1:0] C_1US = CW'(US_CYCLES - 1);
  localparam logic [CW-1:0] C_3US = CW'(3 * US_CYCLES - 1);
  localparam logic [CW-1:0] C_4US = CW'(4 * US_CYCLES - 1);
  localparam logic [CW-1:0] C_SAMP = CW'(2 * US_CYCLES - 1);
  localparam logic [CW-1:0] C_FTO = CW'(FIRST_TO_US * US_CYCLES - 1);
  localparam logic [CW-1:0] C_BTO = CW'(BIT_TO_US * US_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, TX_LOW, TX_HIGH, RX_WAIT, RX_SAMPLE, RX_STOP, CHECK} state_t;
  state_t state;
  logic [PW-1:0] poll_cnt;
  logic [CW-1:0] cnt;
  logic [4:0] tx_bit;
  logic [6:0] rx_bit;
  logic [63:0] resp;
  logic [2:0] sync;
  logic pending, err, stop_seen;
  logic expire, fall, tx_val, ok;
  logic [CW-1:0] low_end, high_end, rx_to;
  always_comb begin
    expire = poll_cnt == PW'(POLL - 1);
    fall = sync[2] & ~sync[1];
    tx_val = TX_WORD[5'd24 - tx_bit];
    low_end = tx_val ? C_1US : C_3US;
    high_end = tx_val ? C_3US : C_1US;
    rx_to = rx_bit == 7'd0 ? C_FTO : C_BTO;
    ok = !err && resp[63:61] == 3'b000 && resp[55];
  end
  // cnt is reset on each detected response edge and left running through RX_SAMPLE,
  // so the bit-to-bit timeout is measured edge to edge rather than from the sample point.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      poll_cnt <= '0;
      cnt <= '0;
      tx_bit <= '0;
      rx_bit <= '0;
      resp <= '0;
      sync <= '1;
      pending <= 1'b0;
      err <= 1'b0;
      stop_seen <= 1'b0;
      bus.data_oe <= 1'b0;
      bus.update <= 1'b0;
      bus.connected <= 1'b0;
      {bus.start_pause, bus.Y, bus.X, bus.B, bus.A} <= 5'd0;
      {bus.L, bus.R, bus.Z, bus.D_UP, bus.D_DOWN, bus.D_RIGHT, bus.D_LEFT} <= 7'd0;
      {bus.JOY_X, bus.JOY_Y, bus.C_STICK_X, bus.C_STICK_Y, bus.L_TRIGGER, bus.R_TRIGGER} <= 48'h8080_8080_0000;
    end else begin
      sync <= {sync[1:0], bus.data_in};
      poll_cnt <= expire ? '0 : poll_cnt + 1'b1;
      pending <= state != IDLE && (pending || expire);
      cnt <= cnt + 1'b1;
      bus.update <= 1'b0;
      case (state)
        IDLE:
          if (expire || pending) begin
            state <= TX_LOW;
            bus.data_oe <= 1'b1;
            cnt <= '0;
            tx_bit <= '0;
            err <= 1'b0;
          end
        TX_LOW:
          if (cnt == low_end) begin
            state <= TX_HIGH;
            bus.data_oe <= 1'b0;
            cnt <= '0;
          end
        TX_HIGH:
          if (cnt == high_end) begin
            cnt <= '0;
            if (tx_bit == 5'd24) begin
              state <= RX_WAIT;
              rx_bit <= '0;
            end else begin
              state <= TX_LOW;
              bus.data_oe <= 1'b1;
              tx_bit <= tx_bit + 1'b1;
            end
          end
        RX_WAIT:
          if (fall) begin
            state <= RX_SAMPLE;
            cnt <= '0;
          end else if (cnt == rx_to) begin
            state <= CHECK;
            err <= 1'b1;
          end
        RX_SAMPLE:
          if (cnt == C_SAMP) begin
            resp <= {resp[62:0], sync[1]};
            rx_bit <= rx_bit + 1'b1;
            stop_seen <= 1'b0;
            state <= rx_bit == 7'd63 ? RX_STOP : RX_WAIT;
          end
        RX_STOP:
          if (!stop_seen && fall) begin
            stop_seen <= 1'b1;
            cnt <= '0;
          end else if (!stop_seen && cnt == C_BTO) begin
            state <= CHECK;
            err <= 1'b1;
          end else if (stop_seen && cnt == C_4US) begin
            state <= CHECK;
          end
        CHECK: begin
          state <= IDLE;
          bus.connected <= ok;
          if (ok) begin
            bus.update <= 1'b1;
            {bus.start_pause, bus.Y, bus.X, bus.B, bus.A} <= resp[60:56];
            {bus.L, bus.R, bus.Z, bus.D_UP, bus.D_DOWN, bus.D_RIGHT, bus.D_LEFT} <= resp[54:48];
            {bus.JOY_X, bus.JOY_Y, bus.C_STICK_X, bus.C_STICK_Y, bus.L_TRIGGER, bus.R_TRIGGER} <= resp[47:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
